// File: rtl/direction_input_queue.sv
// Direction-key front end: per-key two-flop synchroniser and debouncer, rising-edge
// press detection with highest-index priority, and a small event FIFO with valid/ready drain.
module direction_input_queue #(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16383,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_KEYS-1:0]                key_raw,
  input  logic                               dir_ready,
  input  logic                               clear_overflow,
  output logic                               dir_valid,
  output logic [NUM_KEYS-1:0]                dir_onehot,
  output logic [NUM_KEYS-1:0]                key_held,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               overflow,
  output logic                               multi_press
);

  localparam int unsigned CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned COUNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [COUNT_W-1:0] COUNT_FULL = COUNT_W'(FIFO_DEPTH);

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Synchroniser (pressed = 1 regardless of the board's key polarity)
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] pressed;
  logic [NUM_KEYS-1:0] sync1_q;
  logic [NUM_KEYS-1:0] sync2_q;

  assign pressed = KEY_ACTIVE_LOW ? ~key_raw : key_raw;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two sync stages into one.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= pressed;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce: a new level is accepted after DEBOUNCE_CYCLES consecutive mismatches
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] stable_q;
  logic [NUM_KEYS-1:0] stable_d;
  logic [NUM_KEYS-1:0] rise_q;
  logic [NUM_KEYS-1:0] rise_d;

  // NOTE: every always_comb output gets a default before any branch; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    rise_d = stable_d & ~stable_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stable_q <= '0;
      rise_q   <= '0;
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      rise_q   <= rise_d;
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Event select: highest-index rising key wins, the rest are dropped
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] sel_onehot;
  logic                push;
  logic                multi_d;

  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      if (rise_q[i]) begin
        sel_onehot    = '0;
        sel_onehot[i] = 1'b1;
      end
    end
    push    = |rise_q;
    multi_d = ($countones(rise_q) > 1);
  end

  // ---------------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [COUNT_W-1:0]  count_q, count_d;
  logic                overflow_q, overflow_d;
  logic                multi_q;
  logic                pop;
  logic                full;
  logic                do_push;
  logic                drop;

  always_comb begin
    pop     = (count_q != '0) && dir_ready;
    full    = (count_q == COUNT_FULL);
    // A pop on the same edge frees the slot the push needs.
    do_push = push && (!full || pop);
    drop    = push && full && !pop;

    wr_ptr_d = do_push ? ptr_next(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_next(rd_ptr_q) : rd_ptr_q;

    count_d = count_q;
    if (do_push && !pop) begin
      count_d = count_q + COUNT_W'(1);
    end else if (pop && !do_push) begin
      count_d = count_q - COUNT_W'(1);
    end

    overflow_d = (overflow_q && !clear_overflow) || drop;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      multi_q    <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      multi_q    <= multi_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; an entry is only read
  // while count says it holds data, and the head output is masked when empty.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= sel_onehot;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs, all driven from flops
  // ---------------------------------------------------------------------------
  assign dir_valid   = (count_q != '0);
  assign dir_onehot  = dir_valid ? mem_q[rd_ptr_q] : '0;
  assign key_held    = stable_q;
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;
  assign multi_press = multi_q;

endmodule
